alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_cmd_fifo.sv | 65 ++++++
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
// Holds the ALU opcode constants, the sequencer FSM state type, the captured
// response record and the saturating error-counter update helper.
package alu_pkg;

    // Width of the ALU the sequencer is paired with; the response record is sized for it.
    localparam int ALU_BITS = 8;

    // ALU opcodes
    localparam logic [1:0] OP_SUB = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_CHG = 2'b11;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } seq_state_t;

    // One captured ALU response: issued op, result and the four ALU flags
    typedef struct packed {
        logic [1:0]          op;
        logic [ALU_BITS-1:0] out;
        logic                ovf;
        logic                err;
        logic                even;
        logic                single;
    } alu_rsp_t;

    // Next value of the 8-bit saturating error counter; clear has priority over increment
    function automatic logic [7:0] err_cnt_next(input logic [7:0] cnt,
                                                input logic       inc,
                                                input logic       clr);
        logic [7:0] nxt;
        if (clr) begin
            nxt = 8'h00;
        end else if (inc && (cnt != 8'hFF)) begin
            nxt = cnt + 8'h01;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer.
// Ports: clk/rst_n (async active-low), push/push_data (write, ignored when full),
// pop/pop_data (pop_data is the current head, pop ignored when empty),
// full/empty status derived from the registered occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage write; data needs no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU command sequencer.
// Queues commands (i_cmd_valid/o_cmd_ready, i_cmd_op/a/b) in a FIFO, issues
// them one at a time to an external ALU through registered o_alu_op/a/b,
// captures the ALU result and flags (i_alu_*) one cycle later and presents
// them as a held response (o_rsp_valid/i_rsp_ready, o_rsp_*). o_err_cnt
// counts accepted responses flagged with err, saturating at 255, and is
// zeroed by i_clr_cnt. The ALU itself lives outside this block.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int BITS  = ALU_BITS,
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [1:0]      i_cmd_op,
    input  logic [BITS-1:0] i_cmd_a,
    input  logic [BITS-1:0] i_cmd_b,
    output logic [1:0]      o_alu_op,
    output logic [BITS-1:0] o_alu_a,
    output logic [BITS-1:0] o_alu_b,
    input  logic [BITS-1:0] i_alu_out,
    input  logic            i_alu_ovf,
    input  logic            i_alu_err,
    input  logic            i_alu_even,
    input  logic            i_alu_single,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [1:0]      o_rsp_op,
    output logic [BITS-1:0] o_rsp_out,
    output logic            o_rsp_ovf,
    output logic            o_rsp_err,
    output logic            o_rsp_even,
    output logic            o_rsp_single,
    input  logic            i_clr_cnt,
    output logic [7:0]      o_err_cnt
);

    localparam int CMD_W = 2 + 2 * BITS;

    seq_state_t       state_r;
    logic [1:0]       alu_op_r;
    logic [BITS-1:0]  alu_a_r;
    logic [BITS-1:0]  alu_b_r;
    alu_rsp_t         rsp_r;
    logic             rsp_valid_r;
    logic [7:0]       err_cnt_r;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             fifo_pop_s;
    logic             rsp_fire_s;
    logic [CMD_W-1:0] cmd_word_s;
    logic [CMD_W-1:0] head_s;

    assign cmd_word_s  = {i_cmd_op, i_cmd_a, i_cmd_b};
    assign o_cmd_ready = ~fifo_full_s;
    assign rsp_fire_s  = rsp_valid_r & i_rsp_ready;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (i_cmd_valid),
        .push_data (cmd_word_s),
        .pop       (fifo_pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Head is consumed when idle, or when the held response is accepted so the next issue follows immediately
    always_comb begin
        fifo_pop_s = 1'b0;
        case (state_r)
            ST_IDLE: fifo_pop_s = ~fifo_empty_s;
            ST_RESP: fifo_pop_s = i_rsp_ready & ~fifo_empty_s;
            default: fifo_pop_s = 1'b0;
        endcase
    end

    // Sequencer FSM: issue operands, capture ALU result one cycle later, hold response until accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            alu_op_r    <= 2'b00;
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            rsp_r       <= '0;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        alu_op_r <= head_s[CMD_W-1 -: 2];
                        alu_a_r  <= head_s[2*BITS-1 -: BITS];
                        alu_b_r  <= head_s[BITS-1:0];
                        state_r  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rsp_r.op     <= alu_op_r;
                    rsp_r.out    <= i_alu_out;
                    rsp_r.ovf    <= i_alu_ovf;
                    rsp_r.err    <= i_alu_err;
                    rsp_r.even   <= i_alu_even;
                    rsp_r.single <= i_alu_single;
                    rsp_valid_r  <= 1'b1;
                    state_r      <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        if (!fifo_empty_s) begin
                            alu_op_r <= head_s[CMD_W-1 -: 2];
                            alu_a_r  <= head_s[2*BITS-1 -: BITS];
                            alu_b_r  <= head_s[BITS-1:0];
                            state_r  <= ST_ISSUE;
                        end else begin
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of accepted error responses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt_r <= 8'h00;
        end else begin
            err_cnt_r <= err_cnt_next(err_cnt_r, rsp_fire_s & rsp_r.err, i_clr_cnt);
        end
    end

    assign o_alu_op     = alu_op_r;
    assign o_alu_a      = alu_a_r;
    assign o_alu_b      = alu_b_r;
    assign o_rsp_valid  = rsp_valid_r;
    assign o_rsp_op     = rsp_r.op;
    assign o_rsp_out    = rsp_r.out;
    assign o_rsp_ovf    = rsp_r.ovf;
    assign o_rsp_err    = rsp_r.err;
    assign o_rsp_even   = rsp_r.even;
    assign o_rsp_single = rsp_r.single;
    assign o_err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. A behavioural 8-bit ALU stub sits
// between o_alu_* and i_alu_*; expected responses are queued when commands
// are accepted and compared in order against responses seen on handshake.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int BITS  = 8;
    localparam int DEPTH = 4;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_cmd_valid = 1'b0;
    logic            o_cmd_ready;
    logic [1:0]      i_cmd_op = 2'b00;
    logic [BITS-1:0] i_cmd_a = 8'h00;
    logic [BITS-1:0] i_cmd_b = 8'h00;
    logic [1:0]      o_alu_op;
    logic [BITS-1:0] o_alu_a;
    logic [BITS-1:0] o_alu_b;
    logic [BITS-1:0] i_alu_out;
    logic            i_alu_ovf;
    logic            i_alu_err;
    logic            i_alu_even;
    logic            i_alu_single;
    logic            o_rsp_valid;
    logic            i_rsp_ready = 1'b0;
    logic [1:0]      o_rsp_op;
    logic [BITS-1:0] o_rsp_out;
    logic            o_rsp_ovf;
    logic            o_rsp_err;
    logic            o_rsp_even;
    logic            o_rsp_single;
    logic            i_clr_cnt = 1'b0;
    logic [7:0]      o_err_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int hold_viol = 0;

    logic     err_force = 1'b0;
    alu_rsp_t stub_s;
    alu_rsp_t cur_s;
    alu_rsp_t prev_rsp = '0;
    logic     prev_hold = 1'b0;
    alu_rsp_t exp_q[$];
    alu_rsp_t obs_q[$];

    always #5 i_clk = ~i_clk;

    alu_sequencer #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
        .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .i_alu_out(i_alu_out), .i_alu_ovf(i_alu_ovf), .i_alu_err(i_alu_err),
        .i_alu_even(i_alu_even), .i_alu_single(i_alu_single),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_op(o_rsp_op), .o_rsp_out(o_rsp_out), .o_rsp_ovf(o_rsp_ovf),
        .o_rsp_err(o_rsp_err), .o_rsp_even(o_rsp_even), .o_rsp_single(o_rsp_single),
        .i_clr_cnt(i_clr_cnt), .o_err_cnt(o_err_cnt)
    );

    // Reference ALU behaviour: used both as the stub driving the DUT and for expectations
    function automatic alu_rsp_t alu_model(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic err);
        alu_rsp_t   r;
        logic [15:0] sh;
        r = '0;
        sh = 16'h0000;
        r.op = op;
        r.err = err;
        case (op)
            OP_SUB: begin
                r.out = a - b;
                r.ovf = (a[7] != b[7]) && (r.out[7] != a[7]);
            end
            OP_CMP: r.out = (a < b) ? 8'hFF : ((a == b) ? 8'h00 : 8'h01);
            OP_SHL: begin
                sh = {8'h00, a} << b[2:0];
                r.out = sh[7:0];
                r.ovf = |sh[15:8];
            end
            default: r.out = a ^ b;
        endcase
        r.even = ~^r.out;
        r.single = (a == b);
        return r;
    endfunction

    always_comb stub_s = alu_model(o_alu_op, o_alu_a, o_alu_b, err_force);
    assign i_alu_out    = stub_s.out;
    assign i_alu_ovf    = stub_s.ovf;
    assign i_alu_err    = stub_s.err;
    assign i_alu_even   = stub_s.even;
    assign i_alu_single = stub_s.single;
    assign cur_s = alu_rsp_t'({o_rsp_op, o_rsp_out, o_rsp_ovf, o_rsp_err, o_rsp_even, o_rsp_single});

    // Response monitor: logs accepted responses and flags any change while a response is held
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (prev_hold && (!o_rsp_valid || (cur_s !== prev_rsp))) begin
                hold_viol <= hold_viol + 1;
            end
            if (o_rsp_valid && i_rsp_ready) begin
                obs_q.push_back(cur_s);
            end
            prev_hold <= o_rsp_valid & ~i_rsp_ready;
            prev_rsp  <= cur_s;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present one command and hold it until accepted; leaves i_cmd_valid high
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int g;
        g = 0;
        i_cmd_valid = 1'b1;
        i_cmd_op = op;
        i_cmd_a = a;
        i_cmd_b = b;
        while (!o_cmd_ready && g < 200) begin
            tick();
            g++;
        end
        n_checks++;
        if (g >= 200) begin
            n_fails++;
            $display("FAIL cmd_accept_timeout: o_cmd_ready=%0b after %0d cycles, required 1", o_cmd_ready, g);
        end else begin
            tick();
            exp_q.push_back(alu_model(op, a, b, err_force));
        end
    endtask

    // Wait until every expected response has been observed and the DUT has gone quiet
    task automatic wait_drain(output bit timed_out);
        int g;
        g = 0;
        while ((obs_q.size() < exp_q.size() || o_rsp_valid) && g < 2000) begin
            tick();
            g++;
        end
        timed_out = (g >= 2000);
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++;
        if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_handshake: ready=%b valid=%b, required ready=1 valid=0", o_cmd_ready, o_rsp_valid);
        end
        n_checks++;
        if (cur_s !== alu_rsp_t'(0) || o_alu_op !== 2'b00 || o_alu_a !== 8'h00 || o_alu_b !== 8'h00 || o_err_cnt !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_values: rsp=%h alu=%h/%h/%h cnt=%h, required all 0", cur_s, o_alu_op, o_alu_a, o_alu_b, o_err_cnt);
        end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sub_latency();
        bit to;
        alu_rsp_t e, o;
        i_rsp_ready = 1'b0;
        send_cmd(OP_SUB, 8'd5, 8'd3);
        i_cmd_valid = 1'b0;
        n_checks++;
        if (o_rsp_valid !== 1'b0) begin n_fails++; $display("FAIL latency_e0: valid=%b, required 0", o_rsp_valid); end
        tick();
        n_checks++;
        if (o_rsp_valid !== 1'b0 || o_alu_op !== OP_SUB || o_alu_a !== 8'd5 || o_alu_b !== 8'd3) begin
            n_fails++;
            $display("FAIL latency_e1: valid=%b alu=%h/%h/%h, required 0 and 0/05/03", o_rsp_valid, o_alu_op, o_alu_a, o_alu_b);
        end
        tick();
        n_checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_op !== 2'b00 || o_rsp_out !== 8'h02 || o_rsp_even !== 1'b0 || o_rsp_single !== 1'b0) begin
            n_fails++;
            $display("FAIL sub_5_3: valid=%b op=%h out=%h even=%b single=%b, required 1 00 02 0 0",
                     o_rsp_valid, o_rsp_op, o_rsp_out, o_rsp_even, o_rsp_single);
        end
        tick(); tick();
        i_rsp_ready = 1'b1;
        wait_drain(to);
        n_checks++;
        if (to) begin n_fails++; $display("FAIL sub_drain: timed out, required drain"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fails++; $display("FAIL sub_order: missing, required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fails++; $display("FAIL sub_order: got %h, required %h", o, e); end end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int stuck;
        alu_rsp_t e, o;
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_cmd(2'(i), 8'(8'h11 * (i + 1)), 8'(i + 1));
        n_checks++;
        if (o_cmd_ready !== 1'b0) begin n_fails++; $display("FAIL bp_full: ready=%b, required 0", o_cmd_ready); end
        i_cmd_op = OP_CHG; i_cmd_a = 8'hEE; i_cmd_b = 8'h01;
        stuck = 0;
        for (int i = 0; i < 3; i++) begin
            if (o_cmd_ready) stuck++;
            tick();
        end
        i_cmd_valid = 1'b0;
        n_checks++;
        if (stuck != 0) begin n_fails++; $display("FAIL bp_stay_full: ready seen %0d times, required 0", stuck); end
        i_rsp_ready = 1'b1;
        wait_drain(to);
        n_checks++;
        if (to || o_cmd_ready !== 1'b1) begin n_fails++; $display("FAIL bp_drain: timeout=%b ready=%b, required 0 1", to, o_cmd_ready); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fails++; $display("FAIL bp_order: missing, required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fails++; $display("FAIL bp_order: got %h, required %h", o, e); end end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fails++; $display("FAIL bp_extra: %0d extra responses, required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        bit to;
        alu_rsp_t e, o;
        logic [1:0] ops [8];
        logic [7:0] as [8];
        logic [7:0] bs [8];
        ops = '{OP_SUB, OP_SUB, OP_CMP, OP_CMP, OP_CMP, OP_SHL, OP_SHL, OP_CHG};
        as  = '{8'h80, 8'h10, 8'h03, 8'h44, 8'h90, 8'h81, 8'h01, 8'h5A};
        bs  = '{8'h01, 8'h10, 8'h09, 8'h44, 8'h02, 8'h03, 8'h07, 8'hFF};
        i_rsp_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send_cmd(ops[i], as[i], bs[i]);
                i_cmd_valid = 1'b0;
            end
            begin
                int g;
                g = 0;
                while (!o_rsp_valid && g < 50) begin tick(); g++; end
                for (int k = 0; k < 15; k++) begin
                    n_checks++;
                    if (o_rsp_valid !== ((k % 2) == 0)) begin
                        n_fails++;
                        $display("FAIL stream_cadence: slot %0d valid=%b, required %0b", k, o_rsp_valid, (k % 2) == 0);
                    end
                    tick();
                end
            end
        join
        wait_drain(to);
        n_checks++;
        if (to) begin n_fails++; $display("FAIL stream_drain: timed out, required drain"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fails++; $display("FAIL stream_order: missing, required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fails++; $display("FAIL stream_order: got %h, required %h", o, e); end end
        end
    endtask

    task automatic test_push_pop_same();
        bit to;
        alu_rsp_t e, o;
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_cmd(OP_SUB, 8'(8'h20 + i), 8'(i));
        i_cmd_valid = 1'b0;
        tick();
        i_rsp_ready = 1'b1;
        send_cmd(OP_CHG, 8'h3C, 8'hC3);
        i_cmd_valid = 1'b0;
        i_rsp_ready = 1'b0;
        n_checks++;
        if (o_cmd_ready !== 1'b1) begin n_fails++; $display("FAIL pushpop_occupancy: ready=%b, required 1", o_cmd_ready); end
        send_cmd(OP_SHL, 8'h0F, 8'h04);
        i_cmd_valid = 1'b0;
        n_checks++;
        if (o_cmd_ready !== 1'b0) begin n_fails++; $display("FAIL pushpop_refill: ready=%b, required 0", o_cmd_ready); end
        i_rsp_ready = 1'b1;
        wait_drain(to);
        n_checks++;
        if (to) begin n_fails++; $display("FAIL pushpop_drain: timed out, required drain"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fails++; $display("FAIL pushpop_order: missing, required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fails++; $display("FAIL pushpop_order: got %h, required %h", o, e); end end
        end
    endtask

    task automatic test_err_count();
        bit to;
        int g;
        alu_rsp_t e, o;
        i_clr_cnt = 1'b1; tick(); i_clr_cnt = 1'b0;
        n_checks++;
        if (o_err_cnt !== 8'd0) begin n_fails++; $display("FAIL err_clear0: cnt=%0d, required 0", o_err_cnt); end
        err_force = 1'b1;
        i_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_cmd(OP_CMP, 8'(i), 8'h01);
        i_cmd_valid = 1'b0;
        wait_drain(to);
        n_checks++;
        if (to || o_err_cnt !== 8'd3) begin n_fails++; $display("FAIL err_count3: timeout=%b cnt=%0d, required 0 3", to, o_err_cnt); end
        for (int i = 0; i < 257; i++) send_cmd(2'(i % 4), 8'(i), 8'(i * 3));
        i_cmd_valid = 1'b0;
        wait_drain(to);
        n_checks++;
        if (to || o_err_cnt !== 8'd255) begin n_fails++; $display("FAIL err_saturate: timeout=%b cnt=%0d, required 0 255", to, o_err_cnt); end
        send_cmd(OP_SUB, 8'h01, 8'h02);
        i_cmd_valid = 1'b0;
        g = 0;
        while (!o_rsp_valid && g < 20) begin tick(); g++; end
        i_clr_cnt = 1'b1;
        tick();
        i_clr_cnt = 1'b0;
        n_checks++;
        if (o_err_cnt !== 8'd0) begin n_fails++; $display("FAIL err_clear_wins: cnt=%0d, required 0", o_err_cnt); end
        wait_drain(to);
        err_force = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fails++; $display("FAIL err_order: missing, required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fails++; $display("FAIL err_order: got %h, required %h", o, e); end end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int stale;
        alu_rsp_t e, o;
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_cmd(OP_CHG, 8'(8'h60 + i), 8'h0F);
        i_cmd_valid = 1'b0;
        tick();
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        n_checks++;
        if (o_rsp_valid !== 1'b0 || o_alu_a !== 8'h61) begin
            n_fails++;
            $display("FAIL rstmid_issue: valid=%b alu_a=%h, required 0 61", o_rsp_valid, o_alu_a);
        end
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_alu_a !== 8'h00 || cur_s !== alu_rsp_t'(0)) begin
            n_fails++;
            $display("FAIL rstmid_immediate: valid=%b ready=%b alu_a=%h rsp=%h, required 0 1 00 0", o_rsp_valid, o_cmd_ready, o_alu_a, cur_s);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (obs_q.size() != 1) begin n_fails++; $display("FAIL rstmid_first: %0d responses, required 1", obs_q.size()); end
        else begin o = obs_q.pop_front(); if (o !== e) begin n_fails++; $display("FAIL rstmid_first: got %h, required %h", o, e); end end
        exp_q.delete();
        obs_q.delete();
        tick(); tick();
        i_rst_n = 1'b1;
        i_rsp_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_rsp_valid) stale++;
            tick();
        end
        n_checks++;
        if (stale != 0 || obs_q.size() != 0) begin n_fails++; $display("FAIL rstmid_stale: %0d valid cycles, required 0", stale); end
        send_cmd(OP_CHG, 8'hA5, 8'h0F);
        i_cmd_valid = 1'b0;
        tick();
        n_checks++;
        if (o_rsp_valid !== 1'b0) begin n_fails++; $display("FAIL rstmid_lat_e1: valid=%b, required 0", o_rsp_valid); end
        tick();
        n_checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_out !== 8'hAA) begin n_fails++; $display("FAIL rstmid_lat_e2: valid=%b out=%h, required 1 aa", o_rsp_valid, o_rsp_out); end
        wait_drain(to);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fails++; $display("FAIL rstmid_order: missing, required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fails++; $display("FAIL rstmid_order: got %h, required %h", o, e); end end
        end
    endtask

    initial begin
        test_reset();
        test_sub_latency();
        test_backpressure();
        test_back_to_back();
        test_push_pop_same();
        test_err_count();
        test_reset_mid();
        n_checks++;
        if (hold_viol != 0) begin n_fails++; $display("FAIL rsp_hold_stable: %0d violations, required 0", hold_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
